// File: rtl/stream_in_burst_feeder_pkg.sv
// Shared definitions for the stream-IN feeder and the stream-IN writer.
package stream_in_burst_feeder_pkg;

   // Word width and burst length used by both the feeder and the writer.
   localparam int DEFAULT_DATA_W      = 32;
   localparam int DEFAULT_BURST_WORDS = 1024;
   localparam int DEFAULT_DEPTH_LOG2  = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      GAP   = 2'd2
   } feeder_state_e;

endpackage

// File: rtl/stream_in_burst_feeder_fifo.sv
// Show-ahead single-clock FIFO: the head word sits in a register so the
// writer can consume it on the same edge the strobe is sampled.
module sync_fifo_fwft
   import stream_in_burst_feeder_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
   input  logic                  clk_100,
   input  logic                  reset_,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_W-1:0]     wr_data,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [DATA_W-1:0]   mem [0:DEPTH-1];
   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;
   logic [DEPTH_LOG2:0] rd_ptr_nxt;
   logic [DATA_W-1:0]   head_nxt;
   logic                do_push;
   logic                do_pop;

   // Pointers carry an extra wrap bit; equal addresses with differing wrap
   // bits means full.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign rd_ptr_nxt = rd_ptr + {{DEPTH_LOG2{1'b0}}, do_pop};

   // Next head: bypass the incoming word when it lands at the new read
   // address, otherwise read storage; hold the old value if nothing remains.
   always_comb begin
      head_nxt = rd_data;
      if (do_push && (wr_ptr == rd_ptr_nxt)) begin
         head_nxt = wr_data;
      end else if (wr_ptr != rd_ptr_nxt) begin
         head_nxt = mem[rd_ptr_nxt[DEPTH_LOG2-1:0]];
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_100) begin
      if (do_push) begin
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
      end
   end

   // Pointer and head-register update.
   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= '0;
      end else begin
         wr_ptr  <= wr_ptr + {{DEPTH_LOG2{1'b0}}, do_push};
         rd_ptr  <= rd_ptr_nxt;
         rd_data <= head_nxt;
      end
   end

endmodule

// File: rtl/stream_in_burst_feeder.sv
// Stream-IN burst feeder: buffers producer words and arms the slave-FIFO
// writer only while a complete burst is sitting in the buffer.
//
//  state | meaning
//  ------+----------------------------------------------------------------
//  IDLE  | waiting for enable and a full burst buffered
//  BURST | mode asserted; each writer strobe pops one word
//  GAP   | one cycle with mode low after a burst; re-arms directly if a
//        | further burst is already buffered
module stream_in_burst_feeder
   import stream_in_burst_feeder_pkg::*;
#(
   parameter int DATA_W      = DEFAULT_DATA_W,
   parameter int DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
   parameter int BURST_WORDS = DEFAULT_BURST_WORDS
) (
   input  logic                  clk_100,
   input  logic                  reset_,
   input  logic                  enable,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  in_ready,
   input  logic                  slwr_streamIN_,
   output logic                  stream_in_mode_selected,
   output logic [DATA_W-1:0]     data_for_output,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  burst_done,
   output logic                  underrun,
   output logic                  overflow
);

   localparam int                DEPTH     = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] BURST_CNT = (DEPTH_LOG2+1)'(BURST_WORDS);
   localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] ONE       = {{DEPTH_LOG2{1'b0}}, 1'b1};

   feeder_state_e       state_q;
   feeder_state_e       state_nxt;
   logic [DEPTH_LOG2:0] remaining_q;
   logic [DEPTH_LOG2:0] remaining_nxt;
   logic [DEPTH_LOG2:0] level_nxt;
   logic                in_ready_q;
   logic                burst_done_q;
   logic                underrun_q;
   logic                overflow_q;
   logic                fifo_full;
   logic                fifo_empty;
   logic                push_acc;
   logic                pop_acc;
   logic                arm;
   logic                last_pop;

   assign push_acc = in_valid && in_ready_q && !fifo_full;
   assign pop_acc  = !slwr_streamIN_ && !fifo_empty;
   assign arm      = enable && (level >= BURST_CNT);
   assign last_pop = (state_q == BURST) && pop_acc && (remaining_q == ONE);

   // Mode drops during the final strobe so the writer exits on that edge.
   assign stream_in_mode_selected = (state_q == BURST) && !last_pop;

   assign level_nxt = level + {{DEPTH_LOG2{1'b0}}, push_acc}
                            - {{DEPTH_LOG2{1'b0}}, pop_acc};

   assign in_ready   = in_ready_q;
   assign burst_done = burst_done_q;
   assign underrun   = underrun_q;
   assign overflow   = overflow_q;

   sync_fifo_fwft #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk_100 (clk_100),
      .reset_  (reset_),
      .push    (push_acc),
      .pop     (pop_acc),
      .wr_data (in_data),
      .rd_data (data_for_output),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   // Burst sequencing: arm, count pops down to the last word, one-cycle gap.
   always_comb begin
      state_nxt     = state_q;
      remaining_nxt = remaining_q;
      case (state_q)
         IDLE: begin
            if (arm) begin
               state_nxt     = BURST;
               remaining_nxt = BURST_CNT;
            end
         end
         BURST: begin
            if (pop_acc) begin
               remaining_nxt = remaining_q - ONE;
               if (remaining_q == ONE) begin
                  state_nxt = GAP;
               end
            end
         end
         GAP: begin
            if (arm) begin
               state_nxt     = BURST;
               remaining_nxt = BURST_CNT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt     = IDLE;
            remaining_nxt = '0;
         end
      endcase
   end

   // State, counter, registered ready and status flags.
   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_) begin
         state_q      <= IDLE;
         remaining_q  <= '0;
         in_ready_q   <= 1'b0;
         burst_done_q <= 1'b0;
         underrun_q   <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         remaining_q  <= remaining_nxt;
         in_ready_q   <= (level_nxt != FULL_CNT);
         burst_done_q <= last_pop;
         if (!slwr_streamIN_ && fifo_empty) begin
            underrun_q <= 1'b1;
         end
         if (in_valid && !in_ready_q) begin
            overflow_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stream_in_burst_feeder.sv
// Bench for the stream-IN burst feeder (16-word buffer, 8-word bursts).
module tb_stream_in_burst_feeder;

   localparam int DW = 32;
   localparam int DL = 4;
   localparam int BW = 8;

   logic          clk_100 = 1'b0;
   logic          reset_;
   logic          enable;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          slwr_streamIN_;
   logic          stream_in_mode_selected;
   logic [DW-1:0] data_for_output;
   logic [DL:0]   level;
   logic          burst_done;
   logic          underrun;
   logic          overflow;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] sb [$];

   always #5 clk_100 = ~clk_100;

   stream_in_burst_feeder #(
      .DATA_W      (DW),
      .DEPTH_LOG2  (DL),
      .BURST_WORDS (BW)
   ) dut (
      .clk_100                 (clk_100),
      .reset_                  (reset_),
      .enable                  (enable),
      .in_valid                (in_valid),
      .in_data                 (in_data),
      .in_ready                (in_ready),
      .slwr_streamIN_          (slwr_streamIN_),
      .stream_in_mode_selected (stream_in_mode_selected),
      .data_for_output         (data_for_output),
      .level                   (level),
      .burst_done              (burst_done),
      .underrun                (underrun),
      .overflow                (overflow)
   );

   task automatic apply_reset();
      @(negedge clk_100);
      reset_ = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; slwr_streamIN_ = 1'b1;
      repeat (2) @(negedge clk_100);
      reset_ = 1'b1;
      sb.delete();
      @(negedge clk_100);
   endtask

   // Pushes n consecutive words; expected values go onto the scoreboard.
   task automatic push_words(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = base + DW'(i);
         sb.push_back(base + DW'(i));
         @(negedge clk_100);
      end
      in_valid = 1'b0;
   endtask

   // Pops n words, comparing each head against the scoreboard; rem > 0 also
   // checks that mode drops exactly on the strobe where rem reaches 1.
   task automatic pop_checked(input int n, input int rem);
      logic [DW-1:0] exp_w;
      int r;
      r = rem;
      for (int i = 0; i < n; i++) begin
         exp_w = sb.pop_front();
         checks++;
         if (data_for_output !== exp_w) begin
            errors++;
            $display("FAIL pop_data[%0d]: got %h want %h", i, data_for_output, exp_w);
         end
         slwr_streamIN_ = 1'b0;
         #1;
         if (r > 0) begin
            checks++;
            if (stream_in_mode_selected !== (r != 1)) begin
               errors++;
               $display("FAIL pop_mode[%0d] rem=%0d: got %b want %b", i, r,
                        stream_in_mode_selected, (r != 1));
            end
            r--;
         end
         @(negedge clk_100);
      end
      slwr_streamIN_ = 1'b1;
   endtask

   task automatic test_reset();
      reset_ = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; slwr_streamIN_ = 1'b1;
      repeat (2) @(negedge clk_100);
      checks++;
      if ({in_ready, stream_in_mode_selected, burst_done, underrun, overflow} !== 5'b0 ||
          level !== 0 || data_for_output !== 0) begin
         errors++;
         $display("FAIL reset_values: got rdy=%b mode=%b done=%b ur=%b of=%b lvl=%0d dat=%h want all zero",
                  in_ready, stream_in_mode_selected, burst_done, underrun, overflow, level, data_for_output);
      end
      reset_ = 1'b1;
      @(negedge clk_100);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
      sb.delete();
   endtask

   task automatic test_burst();
      apply_reset();
      enable = 1'b1;
      push_words(8, 32'h0);
      checks++;
      if (level !== 8 || stream_in_mode_selected !== 1'b0) begin
         errors++;
         $display("FAIL burst_prearm: got lvl=%0d mode=%b want 8 0", level, stream_in_mode_selected);
      end
      @(negedge clk_100);
      checks++;
      if (stream_in_mode_selected !== 1'b1 || data_for_output !== 32'h0) begin
         errors++;
         $display("FAIL burst_arm: got mode=%b dat=%h want 1 00000000", stream_in_mode_selected, data_for_output);
      end
      pop_checked(8, 8);
      checks++;
      if (burst_done !== 1'b1 || level !== 0 || stream_in_mode_selected !== 1'b0) begin
         errors++;
         $display("FAIL burst_gap: got done=%b lvl=%0d mode=%b want 1 0 0", burst_done, level, stream_in_mode_selected);
      end
      @(negedge clk_100);
      checks++;
      if (burst_done !== 1'b0) begin
         errors++;
         $display("FAIL burst_done_single: got %b want 0", burst_done);
      end
   endtask

   task automatic test_threshold();
      apply_reset();
      enable = 1'b1;
      push_words(7, 32'h10);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (stream_in_mode_selected !== 1'b0) begin
            errors++;
            $display("FAIL thresh_hold[%0d]: got %b want 0", i, stream_in_mode_selected);
         end
         @(negedge clk_100);
      end
      push_words(1, 32'h17);
      @(negedge clk_100);
      checks++;
      if (stream_in_mode_selected !== 1'b1 || data_for_output !== 32'h10) begin
         errors++;
         $display("FAIL thresh_arm: got mode=%b dat=%h want 1 00000010", stream_in_mode_selected, data_for_output);
      end
   endtask

   task automatic test_full_overflow();
      logic [DW-1:0] exp_w;
      apply_reset();
      push_words(16, 32'h20);
      checks++;
      if (in_ready !== 1'b0 || level !== 16 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_state: got rdy=%b lvl=%0d of=%b want 0 16 0", in_ready, level, overflow);
      end
      in_valid = 1'b1; in_data = 32'hDEAD;
      @(negedge clk_100);
      in_valid = 1'b0;
      checks++;
      if (overflow !== 1'b1 || level !== 16) begin
         errors++;
         $display("FAIL overflow_set: got of=%b lvl=%0d want 1 16", overflow, level);
      end
      // Push and pop while full: pop happens, push refused.
      exp_w = sb.pop_front();
      checks++;
      if (data_for_output !== exp_w) begin
         errors++;
         $display("FAIL full_pp_head: got %h want %h", data_for_output, exp_w);
      end
      in_valid = 1'b1; in_data = 32'hBEEF; slwr_streamIN_ = 1'b0;
      @(negedge clk_100);
      in_valid = 1'b0; slwr_streamIN_ = 1'b1;
      checks++;
      if (level !== 15 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_pp_level: got lvl=%0d rdy=%b want 15 1", level, in_ready);
      end
      // Push and pop with room: level unchanged.
      exp_w = sb.pop_front();
      sb.push_back(32'hCAFE);
      checks++;
      if (data_for_output !== exp_w) begin
         errors++;
         $display("FAIL pp_head: got %h want %h", data_for_output, exp_w);
      end
      in_valid = 1'b1; in_data = 32'hCAFE; slwr_streamIN_ = 1'b0;
      @(negedge clk_100);
      in_valid = 1'b0; slwr_streamIN_ = 1'b1;
      checks++;
      if (level !== 15 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL pp_level: got lvl=%0d rdy=%b want 15 1", level, in_ready);
      end
      pop_checked(15, 0);
      checks++;
      if (level !== 0) begin
         errors++;
         $display("FAIL full_drain: got lvl=%0d want 0", level);
      end
   endtask

   task automatic test_pause();
      apply_reset();
      enable = 1'b1;
      push_words(8, 32'h0);
      @(negedge clk_100);
      pop_checked(3, 8);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (stream_in_mode_selected !== 1'b1 || level !== 5) begin
            errors++;
            $display("FAIL pause[%0d]: got mode=%b lvl=%0d want 1 5", i, stream_in_mode_selected, level);
         end
         @(negedge clk_100);
      end
      pop_checked(5, 5);
      checks++;
      if (burst_done !== 1'b1 || level !== 0) begin
         errors++;
         $display("FAIL pause_end: got done=%b lvl=%0d want 1 0", burst_done, level);
      end
      push_words(8, 32'h40);
      repeat (3) @(negedge clk_100);
      checks++;
      if (stream_in_mode_selected !== 1'b0) begin
         errors++;
         $display("FAIL no_rearm_disabled: got %b want 0", stream_in_mode_selected);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      enable = 1'b1;
      push_words(16, 32'h0);
      checks++;
      if (stream_in_mode_selected !== 1'b1 || level !== 16) begin
         errors++;
         $display("FAIL b2b_armed: got mode=%b lvl=%0d want 1 16", stream_in_mode_selected, level);
      end
      pop_checked(8, 8);
      checks++;
      if (stream_in_mode_selected !== 1'b0 || burst_done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap: got mode=%b done=%b want 0 1", stream_in_mode_selected, burst_done);
      end
      @(negedge clk_100);
      checks++;
      if (stream_in_mode_selected !== 1'b1 || data_for_output !== 32'h8) begin
         errors++;
         $display("FAIL b2b_rearm: got mode=%b dat=%h want 1 00000008", stream_in_mode_selected, data_for_output);
      end
      pop_checked(8, 8);
      checks++;
      if (burst_done !== 1'b1 || level !== 0) begin
         errors++;
         $display("FAIL b2b_end: got done=%b lvl=%0d want 1 0", burst_done, level);
      end
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      enable = 1'b1;
      push_words(8, 32'h50);
      @(negedge clk_100);
      pop_checked(4, 8);
      reset_ = 1'b0;
      #1;
      checks++;
      if (stream_in_mode_selected !== 1'b0 || data_for_output !== 0 || level !== 0 ||
          in_ready !== 1'b0 || burst_done !== 1'b0) begin
         errors++;
         $display("FAIL midreset: got mode=%b dat=%h lvl=%0d rdy=%b done=%b want all zero",
                  stream_in_mode_selected, data_for_output, level, in_ready, burst_done);
      end
      sb.delete();
      @(negedge clk_100);
      reset_ = 1'b1;
      @(negedge clk_100);
      checks++;
      if (level !== 0 || in_ready !== 1'b1 || stream_in_mode_selected !== 1'b0) begin
         errors++;
         $display("FAIL midreset_release: got lvl=%0d rdy=%b mode=%b want 0 1 0", level, in_ready, stream_in_mode_selected);
      end
   endtask

   task automatic test_underrun();
      apply_reset();
      checks++;
      if (underrun !== 1'b0) begin
         errors++;
         $display("FAIL underrun_clear: got %b want 0", underrun);
      end
      slwr_streamIN_ = 1'b0;
      @(negedge clk_100);
      slwr_streamIN_ = 1'b1;
      checks++;
      if (underrun !== 1'b1 || level !== 0 || data_for_output !== 0) begin
         errors++;
         $display("FAIL underrun_set: got ur=%b lvl=%0d dat=%h want 1 0 0", underrun, level, data_for_output);
      end
      @(negedge clk_100);
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("FAIL underrun_sticky: got %b want 1", underrun);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_burst();
      test_threshold();
      test_full_overflow();
      test_pause();
      test_back_to_back();
      test_reset_mid_burst();
      test_underrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
